// File: rtl/frogger_round_if.sv
// Signal bundle between the key decoder / frog / lily-pad blocks and the round sequencer.
// start and dead_frog are levels; dead and win are single-frame pulses sampled on frame_clk.
interface frogger_round_if;
    logic            start;
    logic            dead_frog;
    logic [10:0]     FrogX;
    logic [10:0]     FrogY;
    logic            active;
    logic            frog_reset;
    logic            dead;
    logic            win;
    logic            game_over;
    logic [2:0]      lives;
    logic [2:0]      level;
    logic [3:0]      homes_filled;
    logic [10:0]     round_timer;
    logic [15:0]     score;
    logic [3:0][5:0] LPad_Speed;

    modport master (
        output start, dead_frog, FrogX, FrogY,
        input  active, frog_reset, dead, win, game_over, lives, level,
               homes_filled, round_timer, score, LPad_Speed
    );

    modport slave (
        input  start, dead_frog, FrogX, FrogY,
        output active, frog_reset, dead, win, game_over, lives, level,
               homes_filled, round_timer, score, LPad_Speed
    );
endinterface

// File: rtl/frogger_round_ctrl.sv
// Round sequencer for one frog lane-set: lives, level, home slots, score, round timer
// and per-lane lily-pad speeds. Every output is registered on frame_clk.
module frogger_round_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int ROUND_FRAMES = 1800,
    parameter int DEATH_FRAMES = 60,
    parameter int HOME_FRAMES  = 30,
    parameter int MAX_LEVEL    = 7,
    parameter int BASE_SPEED   = 40,
    parameter int MIN_SPEED    = 8
) (
    input  logic           frame_clk,
    input  logic           Reset,
    frogger_round_if.slave rnd,
    output logic [2:0]     state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE, S_RESPAWN, S_PLAY, S_DYING, S_SCORED, S_LEVEL_UP, S_OVER
    } state_t;

    localparam logic [15:0]       DEATH_LAST = 16'(DEATH_FRAMES - 1);
    localparam logic [15:0]       HOME_LAST  = 16'(HOME_FRAMES - 1);
    localparam logic signed [6:0] BASE_S     = 7'(BASE_SPEED);
    localparam logic signed [6:0] MIN_S      = 7'(MIN_SPEED);

    state_t      state, next_state;
    logic [15:0] frame_cnt;
    logic        start_q, dead_frog_q, dead_flag;
    logic [3:0]  slot_hit;
    logic        start_rise, dead_rise, at_home, slot_open;
    logic        load_game, do_die, do_score, fault, pulse_dead, tick_timer, do_level;
    logic [16:0] home_sum, level_sum;

    // Signed 7-bit so that high levels on outer lanes floor instead of wrapping.
    function automatic logic [5:0] lane_speed(input logic [2:0] lvl, input logic [1:0] lane);
        logic signed [6:0] raw;
        raw = BASE_S - $signed({2'b00, lvl, 2'b00}) - $signed({4'b0000, lane, 1'b0});
        return (raw < MIN_S) ? MIN_S[5:0] : raw[5:0];
    endfunction

    assign state_dbg = state;

    always_comb begin
        slot_hit = '0;
        for (int k = 0; k < 4; k++) begin
            slot_hit[k] = (rnd.FrogX >= 11'(120 + 160 * k)) && (rnd.FrogX <= 11'(159 + 160 * k));
        end
    end

    always_comb begin
        start_rise = rnd.start && !start_q;
        dead_rise  = rnd.dead_frog && !dead_frog_q;
        at_home    = (rnd.FrogY == 11'd0);
        slot_open  = |(slot_hit & ~rnd.homes_filled);
        load_game  = ((state == S_IDLE) && rnd.start) || ((state == S_OVER) && start_rise);
        do_die     = (state == S_PLAY) && dead_rise;
        do_score   = (state == S_PLAY) && !dead_rise && at_home && slot_open;
        // Wrong home-row landing or timer expiry: ask the frog to die, then wait for its flag.
        fault      = (state == S_PLAY) && !dead_rise &&
                     ((at_home && !slot_open) || (!at_home && (rnd.round_timer == 11'd0)));
        pulse_dead = fault && !dead_flag;
        tick_timer = (state == S_PLAY) && !dead_rise && !at_home && (rnd.round_timer != 11'd0);
        do_level   = (state == S_LEVEL_UP);
        home_sum   = {1'b0, rnd.score} + 17'd50 + {10'd0, rnd.round_timer[10:4]};
        level_sum  = {1'b0, rnd.score} + 17'd1000;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (rnd.start) next_state = S_RESPAWN;
            S_RESPAWN:  next_state = S_PLAY;
            S_PLAY: begin
                if (dead_rise)                  next_state = S_DYING;
                else if (at_home && slot_open)  next_state = S_SCORED;
            end
            S_DYING: begin
                if (frame_cnt == DEATH_LAST)
                    next_state = (rnd.lives == 3'd0) ? S_OVER : S_RESPAWN;
            end
            S_SCORED: begin
                if (frame_cnt == HOME_LAST)
                    next_state = (rnd.homes_filled == 4'hF) ? S_LEVEL_UP : S_RESPAWN;
            end
            S_LEVEL_UP: next_state = S_RESPAWN;
            S_OVER:     if (start_rise) next_state = S_RESPAWN;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state            <= S_IDLE;
            frame_cnt        <= '0;
            start_q          <= 1'b0;
            dead_frog_q      <= 1'b0;
            dead_flag        <= 1'b0;
            rnd.active       <= 1'b0;
            rnd.frog_reset   <= 1'b1;
            rnd.dead         <= 1'b0;
            rnd.win          <= 1'b0;
            rnd.game_over    <= 1'b0;
            rnd.lives        <= 3'd0;
            rnd.level        <= 3'd0;
            rnd.homes_filled <= 4'd0;
            rnd.round_timer  <= 11'd0;
            rnd.score        <= 16'd0;
            for (int i = 0; i < 4; i++) rnd.LPad_Speed[i] <= lane_speed(3'd0, 2'(i));
        end else begin
            state          <= next_state;
            frame_cnt      <= (next_state == state) ? frame_cnt + 16'd1 : 16'd0;
            start_q        <= rnd.start;
            dead_frog_q    <= rnd.dead_frog;
            rnd.active     <= (next_state == S_PLAY);
            rnd.frog_reset <= (next_state == S_IDLE) || (next_state == S_RESPAWN);
            rnd.game_over  <= (next_state == S_OVER);
            rnd.dead       <= pulse_dead;
            rnd.win        <= do_score;
            for (int i = 0; i < 4; i++) rnd.LPad_Speed[i] <= lane_speed(rnd.level, 2'(i));

            if (load_game) begin
                rnd.lives        <= 3'(LIVES_INIT);
                rnd.level        <= 3'd0;
                rnd.score        <= 16'd0;
                rnd.homes_filled <= 4'd0;
            end
            if (state == S_RESPAWN) begin
                rnd.round_timer <= 11'(ROUND_FRAMES);
                dead_flag       <= 1'b0;
            end
            if (pulse_dead) dead_flag <= 1'b1;
            if (do_die && (rnd.lives != 3'd0)) rnd.lives <= rnd.lives - 3'd1;
            if (tick_timer) rnd.round_timer <= rnd.round_timer - 11'd1;
            if (do_score) begin
                rnd.homes_filled <= rnd.homes_filled | slot_hit;
                rnd.score        <= home_sum[16] ? 16'hFFFF : home_sum[15:0];
            end
            if (do_level) begin
                rnd.level        <= (rnd.level >= 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : rnd.level + 3'd1;
                rnd.score        <= level_sum[16] ? 16'hFFFF : level_sum[15:0];
                rnd.homes_filled <= 4'd0;
            end
        end
    end

    // A live frog always has at least one life left.
    always_ff @(posedge frame_clk) begin
        if (!Reset && ((state == S_PLAY) || (state == S_RESPAWN) ||
                       (state == S_SCORED) || (state == S_LEVEL_UP)))
            assert (rnd.lives != 3'd0);
    end
endmodule

// File: tb/tb_frogger_round_ctrl.sv
// Directed-plus-random bench for frogger_round_ctrl against a rule-level model of the game.
module tb_frogger_round_ctrl;
  localparam int ROUND_FRAMES = 1800;
  localparam int DEATH_FRAMES = 60;
  localparam int HOME_FRAMES  = 30;
  localparam int LIVES_INIT   = 3;
  localparam int MAX_LEVEL    = 7;
  localparam int BASE_SPEED   = 40;
  localparam int MIN_SPEED    = 8;

  // clock / reset
  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [2:0] state_dbg;
  frogger_round_if rif();

  frogger_round_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .rnd       (rif),
    .state_dbg (state_dbg)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard / model
  int checks = 0;
  int errors = 0;
  int m_lives, m_level, m_score, m_homes, m_timer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_speed(input int lvl, input int lane);
    int v;
    v = BASE_SPEED - 4 * lvl - 2 * lane;
    return (v < MIN_SPEED) ? MIN_SPEED : v;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".lives"}, 32'(rif.lives), 32'(m_lives));
    check({tag, ".level"}, 32'(rif.level), 32'(m_level));
    check({tag, ".homes"}, 32'(rif.homes_filled), 32'(m_homes));
    check({tag, ".score"}, 32'(rif.score), 32'(m_score));
    check({tag, ".timer"}, 32'(rif.round_timer), 32'(m_timer));
    for (int i = 0; i < 4; i++)
      check($sformatf("%s.lane%0d", tag, i), 32'(rif.LPad_Speed[i]), 32'(exp_speed(m_level, i)));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic play(input int n);
    repeat (n) tick();
    m_timer = m_timer - n;
  endtask

  // Respawn is observed one frame before play resumes with a full timer.
  task automatic expect_respawn_then_play(input string tag);
    check({tag, ".respawn_frog_reset"}, 32'(rif.frog_reset), 32'd1);
    check({tag, ".respawn_active"}, 32'(rif.active), 32'd0);
    rif.dead_frog = 1'b0;
    rif.FrogY     = 11'd400;
    tick();
    m_timer = ROUND_FRAMES;
    check({tag, ".play_active"}, 32'(rif.active), 32'd1);
    check({tag, ".play_frog_reset"}, 32'(rif.frog_reset), 32'd0);
    check_model({tag, ".play"});
  endtask

  task automatic die(input string tag);
    rif.dead_frog = 1'b1;
    tick();
    m_lives--;
    check({tag, ".dying_active"}, 32'(rif.active), 32'd0);
    check_model({tag, ".dying"});
    repeat (DEATH_FRAMES - 1) tick();
    check({tag, ".dying_end_active"}, 32'(rif.active), 32'd0);
    check({tag, ".dying_end_frog_reset"}, 32'(rif.frog_reset), 32'd0);
    check({tag, ".dying_end_game_over"}, 32'(rif.game_over), 32'd0);
    tick();
    if (m_lives == 0) begin
      check({tag, ".over_game_over"}, 32'(rif.game_over), 32'd1);
      check({tag, ".over_active"}, 32'(rif.active), 32'd0);
      check({tag, ".over_frog_reset"}, 32'(rif.frog_reset), 32'd0);
      rif.dead_frog = 1'b0;
      rif.FrogY     = 11'd400;
    end else begin
      expect_respawn_then_play(tag);
    end
  endtask

  task automatic score_slot(input int k, input int x);
    int add;
    int old_level;
    add = 50 + (m_timer >> 4);
    rif.FrogX = 11'(x);
    rif.FrogY = 11'd0;
    tick();
    m_homes = m_homes | (1 << k);
    m_score = sat16(m_score + add);
    check($sformatf("slot%0d.win", k), 32'(rif.win), 32'd1);
    check($sformatf("slot%0d.active", k), 32'(rif.active), 32'd0);
    check_model($sformatf("slot%0d", k));
    rif.FrogY = 11'd400;
    tick();
    check($sformatf("slot%0d.win_once", k), 32'(rif.win), 32'd0);
    repeat (HOME_FRAMES - 2) tick();
    check($sformatf("slot%0d.scored_end_active", k), 32'(rif.active), 32'd0);
    check($sformatf("slot%0d.scored_end_frog_reset", k), 32'(rif.frog_reset), 32'd0);
    tick();
    if (m_homes == 15) begin
      check("level_up.frog_reset", 32'(rif.frog_reset), 32'd0);
      check("level_up.active", 32'(rif.active), 32'd0);
      tick();
      old_level = m_level;
      m_level   = (m_level + 1 > MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
      m_score   = sat16(m_score + 1000);
      m_homes   = 0;
      check("level_up.level", 32'(rif.level), 32'(m_level));
      check("level_up.score", 32'(rif.score), 32'(m_score));
      check("level_up.homes", 32'(rif.homes_filled), 32'd0);
      check("level_up.lane0_lag", 32'(rif.LPad_Speed[0]), 32'(exp_speed(old_level, 0)));
    end
    expect_respawn_then_play($sformatf("slot%0d", k));
  endtask

  task automatic fill_open_slots();
    int open_q[$];
    int idx, k;
    for (int s = 0; s < 4; s++) if (((m_homes >> s) & 1) == 0) open_q.push_back(s);
    while (open_q.size() > 0) begin
      idx = $urandom_range(0, open_q.size() - 1);
      k   = open_q[idx];
      open_q.delete(idx);
      play($urandom_range(1, 300));
      score_slot(k, 120 + 160 * k + $urandom_range(0, 39));
    end
  endtask

  task automatic model_reset();
    m_lives = 0; m_level = 0; m_score = 0; m_homes = 0; m_timer = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".active"}, 32'(rif.active), 32'd0);
    check({tag, ".frog_reset"}, 32'(rif.frog_reset), 32'd1);
    check({tag, ".dead"}, 32'(rif.dead), 32'd0);
    check({tag, ".win"}, 32'(rif.win), 32'd0);
    check({tag, ".game_over"}, 32'(rif.game_over), 32'd0);
    check({tag, ".state_known"}, 32'($isunknown(state_dbg)), 32'd0);
    check_model(tag);
  endtask

  initial begin
    int pulses;
    int gap, x;
    rif.start     = 1'b0;
    rif.dead_frog = 1'b0;
    rif.FrogX     = 11'd300;
    rif.FrogY     = 11'd400;
    Reset         = 1'b1;
    model_reset();
    tick();
    tick();
    check_reset_outputs("reset");

    Reset = 1'b0;
    tick();
    check("idle.frog_reset", 32'(rif.frog_reset), 32'd1);
    check("idle.active", 32'(rif.active), 32'd0);

    // start game
    rif.start = 1'b1;
    tick();
    m_lives = LIVES_INIT;
    check("start.lives", 32'(rif.lives), 32'(LIVES_INIT));
    rif.start = 1'b0;
    expect_respawn_then_play("start");

    // plain death after a random stretch of play
    play($urandom_range(1, 200));
    check_model("before_death");
    die("death1");

    // first home at timer 1600 -> 50 + 100
    play(200);
    score_slot(0, 130);
    check("first_home.score150", 32'(rif.score), 32'd150);

    // landing in the already filled slot: one dead pulse, no score, timer held
    rif.FrogX = 11'd130;
    rif.FrogY = 11'd0;
    tick();
    check("filled.dead", 32'(rif.dead), 32'd1);
    check("filled.win", 32'(rif.win), 32'd0);
    check_model("filled");
    pulses = 0;
    repeat (5) begin
      tick();
      pulses += int'(rif.dead);
    end
    check("filled.no_repulse", 32'(pulses), 32'd0);
    check("filled.timer_held", 32'(rif.round_timer), 32'(m_timer));
    die("death2");

    // remaining slots -> level 1, then climb to and past the level cap
    fill_open_slots();
    check("level1.lane3", 32'(rif.LPad_Speed[3]), 32'd30);
    repeat (6) fill_open_slots();
    check("level7.level", 32'(rif.level), 32'd7);
    check("level7.lane2_floor", 32'(rif.LPad_Speed[2]), 32'd8);
    fill_open_slots();
    check("level_cap.level", 32'(rif.level), 32'd7);

    // full round timeout: timer reaches 0, exactly one dead pulse
    repeat (ROUND_FRAMES) tick();
    m_timer = 0;
    check("timeout.timer0", 32'(rif.round_timer), 32'd0);
    check("timeout.no_early_dead", 32'(rif.dead), 32'd0);
    tick();
    check("timeout.dead", 32'(rif.dead), 32'd1);
    pulses = 0;
    repeat (20) begin
      tick();
      pulses += int'(rif.dead);
    end
    check("timeout.no_repulse", 32'(pulses), 32'd0);
    check_model("timeout");
    die("death3");

    // over: everything frozen
    repeat (10) tick();
    check("over.game_over_held", 32'(rif.game_over), 32'd1);
    check_model("over");

    // restart from over
    rif.start = 1'b1;
    tick();
    m_lives = LIVES_INIT; m_level = 0; m_score = 0; m_homes = 0;
    check("restart.lives", 32'(rif.lives), 32'(m_lives));
    check("restart.score", 32'(rif.score), 32'd0);
    check("restart.level", 32'(rif.level), 32'd0);
    check("restart.game_over", 32'(rif.game_over), 32'd0);
    rif.start = 1'b0;
    expect_respawn_then_play("restart");

    // home row outside every slot
    play($urandom_range(1, 400));
    gap = $urandom_range(0, 4);
    if (gap == 0)      x = $urandom_range(0, 119);
    else if (gap == 4) x = 760 + $urandom_range(0, 1200);
    else               x = 160 * gap + $urandom_range(0, 119);
    rif.FrogX = 11'(x);
    rif.FrogY = 11'd0;
    tick();
    check("gap.dead", 32'(rif.dead), 32'd1);
    check_model("gap");
    tick();
    check("gap.dead_once", 32'(rif.dead), 32'd0);
    die("death4");

    // reset in the middle of dying
    rif.dead_frog = 1'b1;
    tick();
    m_lives--;
    check("mid_dying.active", 32'(rif.active), 32'd0);
    repeat ($urandom_range(1, 40)) tick();
    Reset = 1'b1;
    tick();
    model_reset();
    check_reset_outputs("mid_dying_reset");
    Reset         = 1'b0;
    rif.dead_frog = 1'b0;
    tick();
    check("post_reset.idle_frog_reset", 32'(rif.frog_reset), 32'd1);
    check("post_reset.idle_active", 32'(rif.active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
